mem_stage_unit: RTL
===================

# mem_stage_unit

MEM stage controller of the pipelined MIPS core: consumes the packed EX/MEM bundle, performs the load/store against data memory through a request/acknowledge handshake, resolves the branch decision, and registers the MEM/WB bundle. It stalls the upstream pipeline for multi-cycle memory accesses and reports a sticky bus error on memory timeout.

## Interface
- TIMEOUT, 16, cycles in WAIT without `mem_ack` before the access is abandoned
- `clk`  in  1  system clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `exmem_bundle`  in  108  {dest[107:103], read_Rt[102:71], alu_out[70:39], zero[38], branch_target[37:6], ctrl[5:0]}
- ctrl bits: [5] RegWrite, [4] MemtoReg, [3] Branch, [2] MemRead, [1] MemWrite, [0] BranchNe
- `stall`  out  1  upstream must hold EX/MEM contents this cycle
- `pcsrc`  out  1  take branch this cycle
- `branch_target_out`  out  32  forwarded branch_target
- `mem_req`  out  1  memory request, registered
- `mem_we`  out  1  1 = store, 0 = load
- `mem_addr`  out  32  word-aligned address
- `mem_wdata`  out  32  store data
- `mem_ack`  in  1  memory completed access (one-cycle pulse)
- `mem_rdata`  in  32  load data, valid with `mem_ack`
- `memwb_bundle`  out  71  {RegWrite[70], MemtoReg[69], read_data[68:37], alu_out[36:5], dest[4:0]}
- `bus_err`  out  1  sticky timeout flag
- `misaligned`  out  1  one-cycle pulse, access with alu_out[1:0] != 0

## Operation
- FSM states: IDLE, WAIT, DONE. Reset: IDLE; all outputs and registers 0.
- `access` = (MemRead | MemWrite) & alu_out[1:0]==0 & state==IDLE.
- IDLE, no access: every edge loads `memwb_bundle` from bundle with read_data=0. `stall`=0.
- IDLE, access: `stall`=1 combinationally; on edge latch addr/wdata/we, `mem_req`<=1, counter<=0, `memwb_bundle`<=0 (bubble), go WAIT. MemWrite has priority if both set.
- Misaligned (MemRead|MemWrite with alu_out[1:0]!=0) in IDLE: no request; `misaligned` pulses next cycle; `memwb_bundle` loaded with RegWrite forced 0; no stall.
- WAIT: `stall`=1, `memwb_bundle` held at bubble. On `mem_ack`: capture `mem_rdata` (loads) , `mem_req`<=0, go DONE. Counter increments each WAIT cycle without ack; when counter==TIMEOUT-1 and no ack: `mem_req`<=0, `bus_err`<=1, read data <=0, go DONE.
- DONE: `stall`=0; on edge load `memwb_bundle` from held bundle with captured read data (0 for stores/timeouts); go IDLE. No new access starts in DONE.
- `pcsrc` = state==IDLE & ((Branch & zero) | (BranchNe & ~zero)); combinational. `branch_target_out` = bundle branch_target always.
- `mem_ack` outside WAIT ignored. `bus_err` cleared only by reset.
- All-zero bundle (flushed) is a no-op: no request, RegWrite=0.

## Timing
- Non-memory op: MEM/WB valid 1 edge after presentation, zero stall.
- Memory op with ack N cycles after `mem_req` rises (N>=1): `stall` high for N+1 cycles (IDLE issue cycle + N WAIT cycles); MEM/WB valid at end of DONE, total latency N+2 edges.
- `mem_addr`/`mem_wdata`/`mem_we` stable whenever `mem_req`=1.
- Ack in same cycle as counter reaching TIMEOUT-1: ack wins, no `bus_err`.
- Reset asserted mid-WAIT: `mem_req` and `stall` drop immediately; FSM IDLE; pending access discarded.
- Back-to-back memory ops: second op issues in the IDLE cycle after DONE.

## Test plan
- Reset: drive `reset_n`=0 mid-WAIT -> `mem_req`=0, `memwb_bundle`=0, `bus_err`=0, state IDLE same cycle.
- ALU op (RegWrite, dest=5'd9, alu_out=32'h1234) -> next edge `memwb_bundle` = {1,0,0,32'h1234,9}, `stall` never 1.
- Load addr 32'h100, ack after 3 cycles with rdata 32'hCAFEF00D -> `stall` high 4 cycles, `memwb_bundle` read_data=32'hCAFEF00D, MemtoReg=1, one bubble per stall cycle.
- Store addr 32'h204, wdata 32'hA5A5A5A5, ack after 1 cycle -> `mem_we`=1, data/addr stable while `mem_req`, RegWrite=0 in output.
- No ack with TIMEOUT=4 -> `mem_req` drops after 4 WAIT cycles, `bus_err`=1 stays until reset, pipeline resumes.
- Branch=1, zero=1, target 32'h40 -> `pcsrc`=1, `branch_target_out`=32'h40; BranchNe=1, zero=1 -> `pcsrc`=0; load at addr 32'h102 -> `misaligned` pulse, no `mem_req`.

Source files
------------

// File: rtl/mem_stage_unit_if.sv
// Request/acknowledge bus between the MEM stage and data memory.
// The MEM stage is the master; memory answers with a one-cycle ack pulse.
interface mem_stage_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_stage_unit.sv
// MEM stage of the pipelined MIPS core: data-memory access with handshake and timeout,
// branch resolution and the MEM/WB pipeline register.
module mem_stage_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [107:0]     exmem_bundle,
  output logic             stall,
  output logic             pcsrc,
  output logic [31:0]      branch_target_out,
  mem_stage_unit_if.master mem_bus,
  output logic [70:0]      memwb_bundle,
  output logic             bus_err,
  output logic             misaligned
);
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  logic [4:0]  dest;
  logic [31:0] read_rt, alu_out, branch_target;
  logic        zero, reg_write, mem_to_reg, branch, mem_read, mem_write, branch_ne;

  assign {dest, read_rt, alu_out, zero, branch_target,
          reg_write, mem_to_reg, branch, mem_read, mem_write, branch_ne} = exmem_bundle;

  state_e          state_q, state_d;
  logic            req_q, req_d, we_q, we_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            hold_rw_q, hold_rw_d, hold_mtr_q, hold_mtr_d;
  logic [4:0]      hold_dest_q, hold_dest_d;
  logic [70:0]     memwb_q, memwb_d;
  logic            bus_err_q, bus_err_d, mis_q, mis_d;

  logic is_mem, in_idle, access, mis_access;

  assign is_mem     = mem_read | mem_write;
  assign in_idle    = (state_q == StIdle);
  assign access     = is_mem & (alu_out[1:0] == 2'b00) & in_idle;
  assign mis_access = is_mem & (alu_out[1:0] != 2'b00) & in_idle;

  // Gated by reset_n so the stall drops the moment reset is asserted.
  assign stall             = reset_n & (access | (state_q == StWait));
  assign pcsrc             = in_idle & ((branch & zero) | (branch_ne & ~zero));
  assign branch_target_out = branch_target;

  assign mem_bus.mem_req   = req_q;
  assign mem_bus.mem_we    = we_q;
  assign mem_bus.mem_addr  = addr_q;
  assign mem_bus.mem_wdata = wdata_q;

  assign memwb_bundle = memwb_q;
  assign bus_err      = bus_err_q;
  assign misaligned   = mis_q;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    hold_rw_d   = hold_rw_q;
    hold_mtr_d  = hold_mtr_q;
    hold_dest_d = hold_dest_q;
    memwb_d     = memwb_q;
    bus_err_d   = bus_err_q;
    mis_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          state_d     = StWait;
          req_d       = 1'b1;
          we_d        = mem_write;
          addr_d      = {alu_out[31:2], 2'b00};
          wdata_d     = read_rt;
          rdata_d     = 32'h0;
          cnt_d       = '0;
          hold_rw_d   = reg_write;
          hold_mtr_d  = mem_to_reg;
          hold_dest_d = dest;
          memwb_d     = '0;
        end else begin
          memwb_d = {reg_write & ~mis_access, mem_to_reg, 32'h0, alu_out, dest};
          mis_d   = mis_access;
        end
      end
      StWait: begin
        // Ack wins over a timeout landing in the same cycle.
        if (mem_bus.mem_ack) begin
          if (!we_q) rdata_d = mem_bus.mem_rdata;
          req_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          rdata_d   = 32'h0;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        memwb_d = {hold_rw_q, hold_mtr_q, rdata_q, addr_q, hold_dest_q};
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      cnt_q       <= '0;
      hold_rw_q   <= 1'b0;
      hold_mtr_q  <= 1'b0;
      hold_dest_q <= 5'h0;
      memwb_q     <= '0;
      bus_err_q   <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      hold_rw_q   <= hold_rw_d;
      hold_mtr_q  <= hold_mtr_d;
      hold_dest_q <= hold_dest_d;
      memwb_q     <= memwb_d;
      bus_err_q   <= bus_err_d;
      mis_q       <= mis_d;
    end
  end
endmodule
